vita_tx_sched: RTL and testbench
================================

VITA_TX_SCHED -- requirements
Module: vita_tx_sched

Interface
REQ-001 SHALL have parameter MAXCHAN, default 1, number of 32-bit sample lanes per FIFO line (1..4).
REQ-002 SHALL have derived localparam FIFOWIDTH = 5+64+16+32*MAXCHAN, the deframer sample-FIFO line width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clear  input  1  synchronous flush to IDLE, no error report.
REQ-006 SHALL have port vita_time  input  64  current device time, {secs[63:32], tics[31:0]}.
REQ-007 SHALL have port sample_fifo_i  input  FIFOWIDTH  line: [63:0] send_time, [67:64] seqnum, [79:68] zero, [80] eop, [81] eob, [82] sob, [83] send_at, [84] seqnum_err, [85+:32*MAXCHAN] samples (lane 0 lowest).
REQ-008 SHALL have port sample_fifo_src_rdy_i  input  1  line valid.
REQ-009 SHALL have port sample_fifo_dst_rdy_o  output  1  pop; a line is consumed when src_rdy and dst_rdy are both high.
REQ-010 SHALL have port strobe  input  1  DSP sample request, at most one per cycle.
REQ-011 SHALL have port sample  output  32*MAXCHAN  sample presented to DSP.
REQ-012 SHALL have port run  output  1  high while a burst is being transmitted.
REQ-013 SHALL have port err_stb  output  1  one-cycle event pulse.
REQ-014 SHALL have port err_code  output  8  event code, valid with err_stb.
REQ-015 SHALL have port err_seqnum  output  4  seqnum of offending/finishing line, valid with err_stb.
REQ-016 SHALL have port err_time  output  64  vita_time sampled at the event, valid with err_stb.

Function
REQ-017 States: IDLE, WAIT_TIME, RUN, DRAIN; illegal encodings -> IDLE.
REQ-018 IDLE, head line valid: seqnum_err=1 -> err 0x04 (SEQ), DRAIN; else send_at=1 and send_time<vita_time (unsigned 64-bit) -> err 0x08 (LATE), DRAIN; else send_at=1 and send_time>vita_time -> WAIT_TIME; else -> RUN; line not popped.
REQ-019 WAIT_TIME: when vita_time==send_time -> RUN same cycle; vita_time>send_time -> err 0x08, DRAIN.
REQ-020 RUN: run=1; on strobe with line valid, pop it and register its samples onto sample the next cycle.
REQ-021 RUN: popped line with eob&eop -> err 0x01 (ACK), IDLE; eop without eob -> stay RUN.
REQ-022 RUN: any non-first popped line with seqnum_err=1 -> err 0x04, DRAIN unless it has eob&eop, then IDLE.
REQ-023 sob/send_at on non-first lines SHALL be ignored.
REQ-024 DRAIN: dst_rdy=1 unconditionally; pop until a line with eob&eop is consumed, then IDLE; no further err_stb.
REQ-025 dst_rdy=0 in IDLE and WAIT_TIME; in RUN dst_rdy=strobe.
REQ-026 sample SHALL hold last value between strobes and read zero outside RUN.
REQ-027 Simultaneous events: err_stb SHALL fire at most once per cycle; priority SEQ > LATE > UNDERRUN > ACK.
REQ-028 clear SHALL take precedence over all transitions and events in the same cycle.

Reset
REQ-029 reset_n low SHALL asynchronously force state IDLE, run=0, sample=0, err_stb=0, err_code=0, err_seqnum=0, err_time=0, dst_rdy=0.
REQ-030 Reset mid-burst SHALL abandon the burst with no report; remaining FIFO lines are handled as new bursts.

Configuration
REQ-031 With TX_SCHED_UNDERRUN_EN defined: RUN, strobe with no line valid -> err 0x02 (UNDERRUN), seqnum of last popped line, DRAIN.
REQ-032 Without TX_SCHED_UNDERRUN_EN: that strobe is ignored, sample holds, state stays RUN, no report.

Structure
REQ-033 Package vita_tx_pkg SHALL hold the state enum, the err_code constants, and the FIFO field bit offsets shared with the deframer.
REQ-034 One sub-module, vita_time_cmp (registered-free 64-bit compare giving lt/eq/gt), SHALL be instantiated once.

Verification
REQ-035 Burst of 3 lines, send_at=0, sob on line 1, eob&eop on line 3, strobe every cycle -> 3 samples in order, err_stb code 0x01 seqnum of line 3, IDLE.
REQ-036 send_time=1000, vita_time 990 counting up -> dst_rdy 0 until vita_time==1000, RUN that cycle, first sample next strobe.
REQ-037 send_time=1000, vita_time=1005 -> err 0x08, err_time=1005, all lines to eob&eop popped, no samples, run=0.
REQ-038 Line 2 seqnum_err=1 -> err 0x04 once, drain to eob, next burst transmits normally.
REQ-039 TX_SCHED_UNDERRUN_EN, FIFO empties after line 2, strobe -> err 0x02 seqnum of line 2; without macro, no err_stb and burst completes when line 3 arrives.
REQ-040 reset_n asserted mid-RUN -> all outputs zero immediately; clear mid-burst -> IDLE next cycle, no err_stb.

Source files
------------

// File: rtl/vita_tx_sched_pkg.sv
// Shared VITA TX scheduler types: FSM state, event codes and the deframer
// sample-FIFO line layout.
package vita_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TIME = 2'd1,
    ST_RUN       = 2'd2,
    ST_DRAIN     = 2'd3
  } state_e;

  localparam logic [7:0] ERR_ACK      = 8'h01;
  localparam logic [7:0] ERR_UNDERRUN = 8'h02;
  localparam logic [7:0] ERR_SEQ      = 8'h04;
  localparam logic [7:0] ERR_LATE     = 8'h08;

  // Bit offsets within one sample-FIFO line, identical to the deframer's packing.
  localparam int unsigned OFF_TIME    = 0;
  localparam int unsigned OFF_SEQNUM  = 64;
  localparam int unsigned OFF_EOP     = 80;
  localparam int unsigned OFF_EOB     = 81;
  localparam int unsigned OFF_SOB     = 82;
  localparam int unsigned OFF_SEND_AT = 83;
  localparam int unsigned OFF_SEQ_ERR = 84;
  localparam int unsigned OFF_SAMPLES = 85;

  function automatic int unsigned fifo_width(input int unsigned maxchan);
    return 5 + 64 + 16 + 32 * maxchan;
  endfunction

endpackage

// File: rtl/vita_tx_sched_if.sv
// Sample-FIFO, DSP strobe/sample and event-report signals of vita_tx_sched.
interface vita_tx_sched_if #(
    parameter int unsigned MAXCHAN = 1
);
    import vita_tx_pkg::*;

    localparam int unsigned FIFOWIDTH = fifo_width(MAXCHAN);

    logic [FIFOWIDTH-1:0]  sample_fifo_i;
    logic                  sample_fifo_src_rdy_i;
    logic                  sample_fifo_dst_rdy_o;
    logic                  strobe;
    logic [32*MAXCHAN-1:0] sample;
    logic                  run;
    logic                  err_stb;
    logic [7:0]            err_code;
    logic [3:0]            err_seqnum;
    logic [63:0]           err_time;

    modport slave (
        input  sample_fifo_i, sample_fifo_src_rdy_i, strobe,
        output sample_fifo_dst_rdy_o, sample, run,
               err_stb, err_code, err_seqnum, err_time
    );

    modport master (
        output sample_fifo_i, sample_fifo_src_rdy_i, strobe,
        input  sample_fifo_dst_rdy_o, sample, run,
               err_stb, err_code, err_seqnum, err_time
    );

endinterface

// File: rtl/vita_tx_sched_time_cmp.sv
// Combinational unsigned 64-bit time compare of a against b.
module vita_time_cmp (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic        lt_o,
    output logic        eq_o,
    output logic        gt_o
);

    assign lt_o = (a_i <  b_i);
    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/vita_tx_sched.sv
// Timed-burst TX scheduler feeding DSP samples from the deframer FIFO.
// Define TX_SCHED_UNDERRUN_EN to report and drain on an empty-FIFO strobe.
module vita_tx_sched
    import vita_tx_pkg::*;
#(
    parameter int unsigned MAXCHAN = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic [63:0]  vita_time,
    vita_tx_sched_if.slave bus
);

    localparam int unsigned FIFOWIDTH = 5 + 64 + 16 + 32 * MAXCHAN;
    localparam int unsigned SW        = 32 * MAXCHAN;

    logic [FIFOWIDTH-1:0] line;
    logic                 valid;
    logic [63:0]          l_time;
    logic [3:0]           l_seq;
    logic                 l_end;
    logic                 l_send_at;
    logic                 l_seq_err;
    logic [SW-1:0]        l_samples;
    logic                 unused_fields;

    assign line      = bus.sample_fifo_i;
    assign valid     = bus.sample_fifo_src_rdy_i;
    assign l_time    = line[OFF_TIME +: 64];
    assign l_seq     = line[OFF_SEQNUM +: 4];
    assign l_end     = line[OFF_EOB] & line[OFF_EOP];
    assign l_send_at = line[OFF_SEND_AT];
    assign l_seq_err = line[OFF_SEQ_ERR];
    assign l_samples = line[OFF_SAMPLES +: SW];
    // sob carries no meaning here: any line reaching IDLE starts a burst.
    assign unused_fields = ^{line[79:68], line[OFF_SOB]};

    logic t_lt, t_eq, t_gt;

    vita_time_cmp u_time_cmp (
        .a_i  (vita_time),
        .b_i  (l_time),
        .lt_o (t_lt),
        .eq_o (t_eq),
        .gt_o (t_gt)
    );

    state_e        state_q, state_d;
    logic          first_q, first_d;
    logic [3:0]    last_seq_q, last_seq_d;
    logic [SW-1:0] sample_q, sample_d;
    logic          err_stb_q;
    logic [7:0]    err_code_q;
    logic [3:0]    err_seqnum_q;
    logic [63:0]   err_time_q;

    logic          dst_rdy;
    logic          evt;
    logic [7:0]    evt_code;
    logic [3:0]    evt_seq;

    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        last_seq_d = last_seq_q;
        sample_d   = sample_q;
        dst_rdy    = 1'b0;
        evt        = 1'b0;
        evt_code   = '0;
        evt_seq    = '0;

        case (state_q)
            ST_IDLE: begin
                first_d  = 1'b1;
                sample_d = '0;
                if (valid) begin
                    if (l_seq_err) begin
                        evt      = 1'b1;
                        evt_code = ERR_SEQ;
                        evt_seq  = l_seq;
                        state_d  = ST_DRAIN;
                    end else if (l_send_at && t_gt) begin
                        evt      = 1'b1;
                        evt_code = ERR_LATE;
                        evt_seq  = l_seq;
                        state_d  = ST_DRAIN;
                    end else if (l_send_at && t_lt) begin
                        state_d  = ST_WAIT_TIME;
                    end else begin
                        state_d  = ST_RUN;
                    end
                end
            end

            ST_WAIT_TIME: begin
                sample_d = '0;
                if (valid) begin
                    if (t_eq) begin
                        state_d  = ST_RUN;
                    end else if (t_gt) begin
                        evt      = 1'b1;
                        evt_code = ERR_LATE;
                        evt_seq  = l_seq;
                        state_d  = ST_DRAIN;
                    end
                end
            end

            ST_RUN: begin
                dst_rdy = bus.strobe;
                if (bus.strobe) begin
                    if (valid) begin
                        sample_d   = l_samples;
                        last_seq_d = l_seq;
                        first_d    = 1'b0;
                        // The first line's seqnum_err was already screened in IDLE.
                        if (!first_q && l_seq_err) begin
                            evt      = 1'b1;
                            evt_code = ERR_SEQ;
                            evt_seq  = l_seq;
                            state_d  = l_end ? ST_IDLE : ST_DRAIN;
                        end else if (l_end) begin
                            evt      = 1'b1;
                            evt_code = ERR_ACK;
                            evt_seq  = l_seq;
                            state_d  = ST_IDLE;
                        end
                    end
`ifdef TX_SCHED_UNDERRUN_EN
                    else begin
                        evt      = 1'b1;
                        evt_code = ERR_UNDERRUN;
                        evt_seq  = last_seq_q;
                        state_d  = ST_DRAIN;
                    end
`else
                    else begin
                        sample_d = sample_q;
                    end
`endif
                end
            end

            ST_DRAIN: begin
                dst_rdy  = 1'b1;
                sample_d = '0;
                if (valid && l_end) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // clear overrides the pop, the event and the transition chosen above.
        if (clear) begin
            state_d  = ST_IDLE;
            first_d  = 1'b1;
            sample_d = '0;
            dst_rdy  = 1'b0;
            evt      = 1'b0;
            evt_code = '0;
            evt_seq  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            first_q      <= 1'b1;
            last_seq_q   <= '0;
            sample_q     <= '0;
            err_stb_q    <= 1'b0;
            err_code_q   <= '0;
            err_seqnum_q <= '0;
            err_time_q   <= '0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            last_seq_q <= last_seq_d;
            sample_q   <= sample_d;
            err_stb_q  <= evt;
            if (evt) begin
                err_code_q   <= evt_code;
                err_seqnum_q <= evt_seq;
                err_time_q   <= vita_time;
            end
        end
    end

    assign bus.sample_fifo_dst_rdy_o = dst_rdy;
    assign bus.sample                = sample_q;
    assign bus.run                   = (state_q == ST_RUN);
    assign bus.err_stb               = err_stb_q;
    assign bus.err_code              = err_code_q;
    assign bus.err_seqnum            = err_seqnum_q;
    assign bus.err_time              = err_time_q;

endmodule

// File: tb/tb_vita_tx_sched.sv
// Directed scoreboard bench for vita_tx_sched; FIFO modelled as a queue.
module tb_vita_tx_sched;

    localparam int MAXCHAN = 1;
    localparam int FW      = 5 + 64 + 16 + 32 * MAXCHAN;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic [63:0] vita_time;

    vita_tx_sched_if #(.MAXCHAN(MAXCHAN)) bus ();

    vita_tx_sched #(.MAXCHAN(MAXCHAN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .vita_time (vita_time),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        logic [3:0]  seq;
        logic [63:0] t;
    } err_t;

    logic [FW-1:0] fifo[$];
    logic [31:0]   exp_samp[$];
    err_t          exp_err[$];
    err_t          e;
    int            n_checks = 0;
    int            n_err    = 0;
    logic          samp_due = 1'b0;
    logic          pop_pend = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_line(input logic [3:0] seq, input logic [31:0] samp,
                                              input logic sob, input logic eob, input logic eop,
                                              input logic send_at, input logic seq_err,
                                              input logic [63:0] t);
        logic [FW-1:0] l;
        l        = '0;
        l[63:0]  = t;
        l[67:64] = seq;
        l[80]    = eop;
        l[81]    = eob;
        l[82]    = sob;
        l[83]    = send_at;
        l[84]    = seq_err;
        l[85 +: 32] = samp;
        return l;
    endfunction

    task automatic refresh();
        bus.sample_fifo_i         = (fifo.size() != 0) ? fifo[0] : '0;
        bus.sample_fifo_src_rdy_i = (fifo.size() != 0);
    endtask

    task automatic push(input logic [FW-1:0] l);
        fifo.push_back(l);
        refresh();
    endtask

    task automatic exp_ev(input logic [7:0] code, input logic [3:0] seq, input logic [63:0] t);
        err_t x;
        x.code = code; x.seq = seq; x.t = t;
        exp_err.push_back(x);
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    task automatic wait_drain(input string tag, input int max);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            at_neg();
            ok = (fifo.size() == 0) && !bus.run && (exp_samp.size() == 0) && (exp_err.size() == 0);
        end
        chk(tag, ok, 1'b1);
    endtask

    task automatic wait_run(input string tag, input int max);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            at_neg();
            ok = bus.run;
        end
        chk(tag, ok, 1'b1);
    endtask

    task automatic wait_fifo_empty(input string tag, input int max);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            at_neg();
            ok = (fifo.size() == 0);
        end
        chk(tag, ok, 1'b1);
    endtask

    // Scoreboard: compare DSP samples and event reports as the DUT emits them.
    always @(negedge clk) begin
        if (samp_due) begin
            chk("sample_expected", exp_samp.size() != 0, 1'b1);
            if (exp_samp.size() != 0) chk("sample", bus.sample, exp_samp.pop_front());
        end
        if (bus.err_stb) begin
            chk("err_expected", exp_err.size() != 0, 1'b1);
            if (exp_err.size() != 0) begin
                e = exp_err.pop_front();
                chk("err_code", bus.err_code, e.code);
                chk("err_seqnum", bus.err_seqnum, e.seq);
                chk("err_time", bus.err_time, e.t);
            end
        end
        samp_due = bus.sample_fifo_src_rdy_i && bus.sample_fifo_dst_rdy_o && bus.run && reset_n;
        pop_pend = bus.sample_fifo_src_rdy_i && bus.sample_fifo_dst_rdy_o && reset_n;
    end

    always begin
        @(posedge clk); #1;
        if (pop_pend && fifo.size() != 0) void'(fifo.pop_front());
        pop_pend = 1'b0;
        refresh();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        clear      = 1'b0;
        vita_time  = 64'd500;
        bus.strobe = 1'b0;
        refresh();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_run", bus.run, 1'b0);
        chk("rst_sample", bus.sample, '0);
        chk("rst_err_stb", bus.err_stb, 1'b0);
        chk("rst_err_code", bus.err_code, 8'h00);
        chk("rst_err_seqnum", bus.err_seqnum, 4'h0);
        chk("rst_err_time", bus.err_time, 64'd0);
        chk("rst_dst_rdy", bus.sample_fifo_dst_rdy_o, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Immediate burst, three lines, strobe every cycle.
        step();
        push(mk_line(4'h1, 32'hA1, 1, 0, 0, 0, 0, 64'd0));
        push(mk_line(4'h2, 32'hA2, 0, 0, 0, 0, 0, 64'd0));
        push(mk_line(4'h3, 32'hA3, 0, 1, 1, 0, 0, 64'd0));
        exp_samp.push_back(32'hA1);
        exp_samp.push_back(32'hA2);
        exp_samp.push_back(32'hA3);
        exp_ev(8'h01, 4'h3, 64'd500);
        bus.strobe = 1'b1;
        wait_drain("t1_done", 40);
        at_neg();
        chk("t1_sample_zero_idle", bus.sample, '0);

        // Timed burst: nothing moves until vita_time reaches send_time.
        step();
        vita_time = 64'd990;
        push(mk_line(4'h4, 32'hB1, 1, 0, 0, 1, 0, 64'd1000));
        push(mk_line(4'h5, 32'hB2, 0, 1, 1, 1, 0, 64'd0));
        exp_samp.push_back(32'hB1);
        exp_samp.push_back(32'hB2);
        exp_ev(8'h01, 4'h5, 64'd1000);
        for (int v = 991; v <= 1000; v++) begin
            at_neg();
            chk("t2_wait_dst_rdy", bus.sample_fifo_dst_rdy_o, 1'b0);
            chk("t2_wait_run", bus.run, 1'b0);
            step();
            vita_time = 64'(v);
        end
        at_neg();
        chk("t2_run_before_edge", bus.run, 1'b0);
        at_neg();
        chk("t2_run_at_time", bus.run, 1'b1);
        wait_drain("t2_done", 40);

        // Late burst: reported once, drained without samples.
        step();
        vita_time = 64'd1005;
        push(mk_line(4'h6, 32'hC1, 1, 0, 0, 1, 0, 64'd1000));
        push(mk_line(4'h7, 32'hC2, 0, 0, 0, 0, 0, 64'd0));
        push(mk_line(4'h8, 32'hC3, 0, 1, 1, 0, 0, 64'd0));
        exp_ev(8'h08, 4'h6, 64'd1005);
        wait_drain("t3_done", 40);
        chk("t3_sample_zero", bus.sample, '0);
        chk("t3_run", bus.run, 1'b0);

        // Sequence error on line 2, then a clean burst.
        step();
        vita_time = 64'd2000;
        push(mk_line(4'h9, 32'hD1, 1, 0, 0, 0, 0, 64'd0));
        push(mk_line(4'hA, 32'hD2, 0, 0, 0, 0, 1, 64'd0));
        push(mk_line(4'hB, 32'hD3, 0, 1, 1, 0, 0, 64'd0));
        push(mk_line(4'hC, 32'hE1, 1, 0, 0, 0, 0, 64'd0));
        push(mk_line(4'hD, 32'hE2, 0, 1, 1, 0, 0, 64'd0));
        exp_samp.push_back(32'hD1);
        exp_samp.push_back(32'hD2);
        exp_samp.push_back(32'hE1);
        exp_samp.push_back(32'hE2);
        exp_ev(8'h04, 4'hA, 64'd2000);
        exp_ev(8'h01, 4'hD, 64'd2000);
        wait_drain("t4_done", 60);

        // FIFO runs dry mid-burst while strobes continue.
        step();
        vita_time = 64'd3000;
        push(mk_line(4'h1, 32'hF1, 1, 0, 0, 0, 0, 64'd0));
        push(mk_line(4'h2, 32'hF2, 0, 0, 0, 0, 0, 64'd0));
        exp_samp.push_back(32'hF1);
        exp_samp.push_back(32'hF2);
`ifdef TX_SCHED_UNDERRUN_EN
        exp_ev(8'h02, 4'h2, 64'd3000);
        wait_fifo_empty("t5_fifo_empty", 40);
        repeat (3) at_neg();
        chk("t5_underrun_run", bus.run, 1'b0);
        step();
        push(mk_line(4'h3, 32'hF3, 0, 1, 1, 0, 0, 64'd0));
        wait_drain("t5_done", 40);
`else
        wait_fifo_empty("t5_fifo_empty", 40);
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("t5_hold_run", bus.run, 1'b1);
            chk("t5_hold_sample", bus.sample, 32'hF2);
        end
        step();
        push(mk_line(4'h3, 32'hF3, 0, 1, 1, 0, 0, 64'd0));
        exp_samp.push_back(32'hF3);
        exp_ev(8'h01, 4'h3, 64'd3000);
        wait_drain("t5_done", 40);
`endif

        // Asynchronous reset in the middle of a burst.
        step();
        vita_time  = 64'd4000;
        bus.strobe = 1'b0;
        push(mk_line(4'h3, 32'h11, 1, 0, 0, 0, 0, 64'd0));
        push(mk_line(4'h4, 32'h22, 0, 0, 0, 0, 0, 64'd0));
        wait_run("t6_run", 20);
        step();
        bus.strobe = 1'b1;
        exp_samp.push_back(32'h11);
        step();
        bus.strobe = 1'b0;
        at_neg();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_run", bus.run, 1'b0);
        chk("t6_rst_sample", bus.sample, '0);
        chk("t6_rst_err_stb", bus.err_stb, 1'b0);
        chk("t6_rst_err_code", bus.err_code, 8'h00);
        chk("t6_rst_err_seqnum", bus.err_seqnum, 4'h0);
        chk("t6_rst_err_time", bus.err_time, 64'd0);
        chk("t6_rst_dst_rdy", bus.sample_fifo_dst_rdy_o, 1'b0);
        #1;
        reset_n = 1'b1;

        // Leftover line starts a new burst; clear then abandons it silently.
        wait_run("t6_restart_run", 20);
        step();
        bus.strobe = 1'b1;
        exp_samp.push_back(32'h22);
        step();
        bus.strobe = 1'b0;
        push(mk_line(4'h5, 32'h33, 0, 1, 1, 0, 0, 64'd0));
        step();
        clear      = 1'b1;
        bus.strobe = 1'b1;
        at_neg();
        chk("t6_clear_dst_rdy", bus.sample_fifo_dst_rdy_o, 1'b0);
        step();
        clear      = 1'b0;
        bus.strobe = 1'b0;
        at_neg();
        chk("t6_clear_run", bus.run, 1'b0);
        chk("t6_clear_sample", bus.sample, '0);
        chk("t6_clear_fifo_kept", fifo.size(), 1);
        step();
        bus.strobe = 1'b1;
        exp_samp.push_back(32'h33);
        exp_ev(8'h01, 4'h5, 64'd4000);
        wait_drain("t6_done", 40);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
